key_event_ctrl: RTL and testbench

KEY_EVENT_CTRL -- requirements
Module: key_event_ctrl

---
 rtl/key_event_pkg.sv | 20 ++
 rtl/ms_tick_gen.sv | 32 +++
 rtl/key_event_ctrl.sv | 138 +++++++++++++
 tb/tb_key_event_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_event_pkg.sv
// rtl/key_event_pkg.sv - shared FSM states, event codes and width helper for key_event_ctrl
package key_event_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HELD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    localparam logic [1:0] EVT_NONE   = 2'd0;
    localparam logic [1:0] EVT_SHORT  = 2'd1;
    localparam logic [1:0] EVT_LONG   = 2'd2;
    localparam logic [1:0] EVT_REPEAT = 2'd3;

    // Bits needed to hold 0..n_states-1; never narrower than one bit.
    function automatic int cnt_width(input int n_states);
        return (n_states > 1) ? $clog2(n_states) : 1;
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// rtl/ms_tick_gen.sv - mod-CYC_PER_MS prescaler producing a 1 ms tick on terminal count
module ms_tick_gen
    import key_event_pkg::*;
#(
    parameter int CYC_PER_MS = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    output logic o_tick
);

    localparam int              PW   = cnt_width(CYC_PER_MS);
    localparam logic [PW-1:0]   TERM = PW'(CYC_PER_MS - 1);

    logic [PW-1:0] r_cnt;
    logic          w_term;

    assign w_term = (r_cnt == TERM);
    assign o_tick = w_term;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (w_term) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/key_event_ctrl.sv
// rtl/key_event_ctrl.sv - single-owner key event FSM emitting SHORT, LONG and REPEAT events
module key_event_ctrl
    import key_event_pkg::*;
#(
    parameter int NKEY       = 4,
    parameter int CYC_PER_MS = 50000,
    parameter int LONG_MS    = 1000,
    parameter int REPEAT_MS  = 200
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NKEY-1:0]              key_level,
    input  logic [NKEY-1:0]              key_press,
    output logic                         evt_valid,
    output logic [cnt_width(NKEY)-1:0]   evt_id,
    output logic [1:0]                   evt_type,
    output logic                         busy
);

    localparam int            IDW       = cnt_width(NKEY);
    localparam int            MS_MAX    = (LONG_MS > REPEAT_MS) ? LONG_MS : REPEAT_MS;
    localparam int            MW        = cnt_width(MS_MAX);
    localparam logic [MW-1:0] LONG_LAST = MW'(LONG_MS - 1);
    localparam logic [MW-1:0] REP_LAST  = MW'(REPEAT_MS - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDW-1:0]   r_owner;
    logic [IDW-1:0]   w_press_idx;
    logic [MW-1:0]    r_ms;
    logic             w_tick;
    logic             w_latch;
    logic             w_ms_restart;
    logic             w_fire;
    logic [1:0]       w_evt_type;
    logic             w_owner_up;
    logic             r_evt_valid;
    logic [IDW-1:0]   r_evt_id;
    logic [1:0]       r_evt_type;

    ms_tick_gen #(
        .CYC_PER_MS (CYC_PER_MS)
    ) u_ms_tick (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_latch),
        .o_tick (w_tick)
    );

    // Descending scan so the lowest set index is the one left standing.
    always_comb begin
        w_press_idx = '0;
        for (int i = NKEY - 1; i >= 0; i--) begin
            if (key_press[i]) begin
                w_press_idx = IDW'(i);
            end
        end
    end

    assign w_owner_up = key_level[r_owner];

    // A release always takes precedence over a threshold reached in the same cycle.
    always_comb begin
        w_state_nxt  = r_state;
        w_latch      = 1'b0;
        w_ms_restart = 1'b0;
        w_fire       = 1'b0;
        w_evt_type   = EVT_NONE;
        case (r_state)
            ST_IDLE: begin
                if (|key_press) begin
                    w_latch     = 1'b1;
                    w_state_nxt = ST_HELD;
                end
            end
            ST_HELD: begin
                if (w_owner_up) begin
                    w_fire      = 1'b1;
                    w_evt_type  = EVT_SHORT;
                    w_state_nxt = ST_IDLE;
                end else if (w_tick && (r_ms == LONG_LAST)) begin
                    w_fire       = 1'b1;
                    w_evt_type   = EVT_LONG;
                    w_ms_restart = 1'b1;
                    w_state_nxt  = ST_REPEAT;
                end
            end
            ST_REPEAT: begin
                if (w_owner_up) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_tick && (r_ms == REP_LAST)) begin
                    w_fire       = 1'b1;
                    w_evt_type   = EVT_REPEAT;
                    w_ms_restart = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner     <= '0;
            r_ms        <= '0;
            r_evt_valid <= 1'b0;
            r_evt_id    <= '0;
            r_evt_type  <= EVT_NONE;
        end else begin
            if (w_latch) begin
                r_owner <= w_press_idx;
            end
            if (w_latch || w_ms_restart) begin
                r_ms <= '0;
            end else if (w_tick && (r_state != ST_IDLE)) begin
                r_ms <= r_ms + 1'b1;
            end
            r_evt_valid <= w_fire;
            r_evt_id    <= w_fire ? r_owner : '0;
            r_evt_type  <= w_fire ? w_evt_type : EVT_NONE;
        end
    end

    assign evt_valid = r_evt_valid;
    assign evt_id    = r_evt_id;
    assign evt_type  = r_evt_type;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_key_event_ctrl.sv
// tb/tb_key_event_ctrl.sv - directed self-checking bench for key_event_ctrl
module tb_key_event_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] key_level;
    logic [3:0] key_press;
    logic       evt_valid;
    logic [1:0] evt_id;
    logic [1:0] evt_type;
    logic       busy;

    typedef struct packed {
        logic [31:0] edge_n;
        logic [31:0] id;
        logic [31:0] typ;
    } ev_t;

    ev_t ev_q[$];
    ev_t exp_q[$];
    int  edge_cnt = 0;
    int  idle_bad = 0;
    int  total    = 0;
    int  bad      = 0;

    key_event_ctrl #(
        .NKEY       (4),
        .CYC_PER_MS (10),
        .LONG_MS    (5),
        .REPEAT_MS  (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_level (key_level),
        .key_press (key_press),
        .evt_valid (evt_valid),
        .evt_id    (evt_id),
        .evt_type  (evt_type),
        .busy      (busy)
    );

    always #10 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            if (evt_valid === 1'b1) begin
                ev_q.push_back(ev_t'{32'(edge_cnt), 32'(evt_id), 32'(evt_type)});
            end else if (evt_id !== 2'd0 || evt_type !== 2'd0) begin
                idle_bad++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] mask, output int t);
        key_press = mask;
        key_level = key_level & ~mask;
        step();
        t = edge_cnt;
        key_press = 4'b0000;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        key_press = 4'b1111;
        key_level = 4'b0000;
        repeat (3) step();
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", evt_valid); end
        total++; if (evt_id !== 2'd0) begin bad++; $display("FAIL reset_id: got %0d want 0", evt_id); end
        total++; if (evt_type !== 2'd0) begin bad++; $display("FAIL reset_type: got %0d want 0", evt_type); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        key_press = 4'b0000;
        key_level = 4'b1111;
        rst = 1'b0;
        ev_q.delete();
        repeat (5) step();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_no_latch busy: got %b want 0", busy); end
        total++; if (ev_q.size() != 0) begin bad++; $display("FAIL reset_no_event: got %0d events want 0", ev_q.size()); end
    endtask

    task automatic test_short();
        int t;
        ev_q.delete(); exp_q.delete();
        press(4'b0100, t);
        repeat (29) step();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL short_busy_held: got %b want 1", busy); end
        key_level[2] = 1'b1;
        step();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL short_busy_fall: got %b want 0", busy); end
        repeat (20) step();
        exp_q.push_back(ev_t'{32'(t + 30), 32'd2, 32'd1});
        total++; if (ev_q.size() != exp_q.size()) begin bad++; $display("FAIL short_count: got %0d want %0d", ev_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
            total++;
            if (ev_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL short_ev%0d: got edge=%0d id=%0d type=%0d want edge=%0d id=%0d type=%0d", i, ev_q[i].edge_n, ev_q[i].id, ev_q[i].typ, exp_q[i].edge_n, exp_q[i].id, exp_q[i].typ);
            end
        end
    endtask

    task automatic test_long_repeat();
        int t;
        ev_q.delete(); exp_q.delete();
        press(4'b0010, t);
        repeat (119) step();
        key_level[1] = 1'b1;
        step();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL long_busy_fall: got %b want 0", busy); end
        repeat (40) step();
        exp_q.push_back(ev_t'{32'(t + 50), 32'd1, 32'd2});
        exp_q.push_back(ev_t'{32'(t + 70), 32'd1, 32'd3});
        exp_q.push_back(ev_t'{32'(t + 90), 32'd1, 32'd3});
        exp_q.push_back(ev_t'{32'(t + 110), 32'd1, 32'd3});
        total++; if (ev_q.size() != exp_q.size()) begin bad++; $display("FAIL long_count: got %0d want %0d", ev_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
            total++;
            if (ev_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL long_ev%0d: got edge=%0d id=%0d type=%0d want edge=%0d id=%0d type=%0d", i, ev_q[i].edge_n, ev_q[i].id, ev_q[i].typ, exp_q[i].edge_n, exp_q[i].id, exp_q[i].typ);
            end
        end
    endtask

    task automatic test_priority();
        int t;
        ev_q.delete(); exp_q.delete();
        press(4'b1010, t);
        repeat (9) step();
        key_level[1] = 1'b1;
        step();
        repeat (10) step();
        key_level[3] = 1'b1;
        step();
        repeat (40) step();
        exp_q.push_back(ev_t'{32'(t + 10), 32'd1, 32'd1});
        total++; if (ev_q.size() != exp_q.size()) begin bad++; $display("FAIL prio_count: got %0d want %0d", ev_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
            total++;
            if (ev_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL prio_ev%0d: got edge=%0d id=%0d type=%0d want edge=%0d id=%0d type=%0d", i, ev_q[i].edge_n, ev_q[i].id, ev_q[i].typ, exp_q[i].edge_n, exp_q[i].id, exp_q[i].typ);
            end
        end
    endtask

    task automatic test_non_owner();
        int t;
        ev_q.delete(); exp_q.delete();
        press(4'b0001, t);
        repeat (19) step();
        key_press = 4'b1000;
        key_level[3] = 1'b0;
        step();
        key_press = 4'b0000;
        repeat (9) step();
        key_level[0] = 1'b1;
        step();
        repeat (10) step();
        key_level[3] = 1'b1;
        repeat (30) step();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL nonowner_busy: got %b want 0", busy); end
        exp_q.push_back(ev_t'{32'(t + 30), 32'd0, 32'd1});
        total++; if (ev_q.size() != exp_q.size()) begin bad++; $display("FAIL nonowner_count: got %0d want %0d", ev_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
            total++;
            if (ev_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL nonowner_ev%0d: got edge=%0d id=%0d type=%0d want edge=%0d id=%0d type=%0d", i, ev_q[i].edge_n, ev_q[i].id, ev_q[i].typ, exp_q[i].edge_n, exp_q[i].id, exp_q[i].typ);
            end
        end
    endtask

    task automatic test_threshold_release();
        int t;
        int t2;
        ev_q.delete(); exp_q.delete();
        press(4'b0100, t);
        repeat (49) step();
        key_level[2] = 1'b1;
        key_press    = 4'b0001;
        key_level[0] = 1'b0;
        step();
        key_press = 4'b0000;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL thr_same_cycle_press busy: got %b want 0", busy); end
        key_level[0] = 1'b1;
        repeat (30) step();
        press(4'b0100, t2);
        repeat (69) step();
        key_level[2] = 1'b1;
        step();
        repeat (40) step();
        exp_q.push_back(ev_t'{32'(t + 50), 32'd2, 32'd1});
        exp_q.push_back(ev_t'{32'(t2 + 50), 32'd2, 32'd2});
        total++; if (ev_q.size() != exp_q.size()) begin bad++; $display("FAIL thr_count: got %0d want %0d", ev_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
            total++;
            if (ev_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL thr_ev%0d: got edge=%0d id=%0d type=%0d want edge=%0d id=%0d type=%0d", i, ev_q[i].edge_n, ev_q[i].id, ev_q[i].typ, exp_q[i].edge_n, exp_q[i].id, exp_q[i].typ);
            end
        end
    endtask

    task automatic test_mid_reset();
        int t;
        int t2;
        ev_q.delete(); exp_q.delete();
        press(4'b0010, t);
        repeat (59) step();
        rst = 1'b1;
        step();
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b want 0", evt_valid); end
        total++; if (evt_id !== 2'd0) begin bad++; $display("FAIL midrst_id: got %0d want 0", evt_id); end
        total++; if (evt_type !== 2'd0) begin bad++; $display("FAIL midrst_type: got %0d want 0", evt_type); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
        rst = 1'b0;
        repeat (100) step();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_still_idle busy: got %b want 0", busy); end
        press(4'b0010, t2);
        repeat (4) step();
        key_level[1] = 1'b1;
        step();
        repeat (10) step();
        exp_q.push_back(ev_t'{32'(t + 50), 32'd1, 32'd2});
        exp_q.push_back(ev_t'{32'(t2 + 5), 32'd1, 32'd1});
        total++; if (ev_q.size() != exp_q.size()) begin bad++; $display("FAIL midrst_count: got %0d want %0d", ev_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
            total++;
            if (ev_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL midrst_ev%0d: got edge=%0d id=%0d type=%0d want edge=%0d id=%0d type=%0d", i, ev_q[i].edge_n, ev_q[i].id, ev_q[i].typ, exp_q[i].edge_n, exp_q[i].id, exp_q[i].typ);
            end
        end
    endtask

    task automatic test_back_to_back();
        int t;
        int t2;
        ev_q.delete(); exp_q.delete();
        press(4'b0100, t);
        repeat (4) step();
        key_level[2] = 1'b1;
        step();
        press(4'b0001, t2);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy: got %b want 1", busy); end
        repeat (2) step();
        key_level[0] = 1'b1;
        step();
        repeat (10) step();
        exp_q.push_back(ev_t'{32'(t + 5), 32'd2, 32'd1});
        exp_q.push_back(ev_t'{32'(t + 9), 32'd0, 32'd1});
        total++; if (ev_q.size() != exp_q.size()) begin bad++; $display("FAIL b2b_count: got %0d want %0d", ev_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
            total++;
            if (ev_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL b2b_ev%0d: got edge=%0d id=%0d type=%0d want edge=%0d id=%0d type=%0d", i, ev_q[i].edge_n, ev_q[i].id, ev_q[i].typ, exp_q[i].edge_n, exp_q[i].id, exp_q[i].typ);
            end
        end
        total++; if (idle_bad != 0) begin bad++; $display("FAIL idle_outputs_zero: got %0d nonzero cycles want 0", idle_bad); end
    endtask

    initial begin
        rst       = 1'b1;
        key_level = 4'b1111;
        key_press = 4'b0000;
        test_reset();
        test_short();
        test_long_repeat();
        test_priority();
        test_non_owner();
        test_threshold_release();
        test_mid_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
